mux_8x1_structural: RTL and testbench

- 8:1 selector for WIDTH-bit data, built structurally as a 3-level tree of 2:1 selects.
- Level 0 uses sel[0]: pairs (d0,d1) (d2,d3) (d4,d5) (d6,d7).
- Level 1 uses sel[1]: pairs the level-0 results.
- Level 2 uses sel[2]: pairs the level-1 results.
- Each level's output can optionally be registered, so the block drops into timing-critical datapaths as a leaf selector. A valid bit travels alongside the data.

---
 rtl/mux_8x1_structural_if.sv | 28 ++
 rtl/mux_8x1_structural.sv | 81 ++++++++
 tb/tb_mux_8x1_structural.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_8x1_structural_if.sv
// Bus bundle for the 8:1 tree selector: eight data words, select,
// request valid in; selected word and result valid out.
interface mux_8x1_structural_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [WIDTH-1:0] d4;
    logic [WIDTH-1:0] d5;
    logic [WIDTH-1:0] d6;
    logic [WIDTH-1:0] d7;
    logic [2:0]       sel;
    logic             in_valid;
    logic [WIDTH-1:0] y;
    logic             out_valid;

    modport master (
        output d0, d1, d2, d3, d4, d5, d6, d7, sel, in_valid,
        input  y, out_valid
    );

    modport slave (
        input  d0, d1, d2, d3, d4, d5, d6, d7, sel, in_valid,
        output y, out_valid
    );
endinterface

// File: rtl/mux_8x1_structural.sv
// 8:1 selector built as a 3-level tree of 2:1 selects. Level i consumes
// sel[i]; each level's result may be registered (STAGE_REGS[i]) together
// with the select bits and the valid bit, so a result always travels with
// the select it was issued with. Latency = popcount(STAGE_REGS).
module mux_8x1_structural #(
    parameter int         WIDTH      = 1,
    parameter logic [2:0] STAGE_REGS = 3'b100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_8x1_structural_if.slave  bus
);

    for (genvar i = 0; i < 3; i++) begin : lvl
        // Number of 2:1 elements at this level (4, 2, 1).
        localparam int NOUT = 4 >> i;

        logic [7:0][WIDTH-1:0] in_data;
        logic [2:0]            in_sel;
        logic                  in_vld;
        logic [7:0][WIDTH-1:0] res_d;
        logic [2:0]            sel_d;
        logic                  vld_d;
        logic [7:0][WIDTH-1:0] out_data;
        logic [2:0]            out_sel;
        logic                  out_vld;

        if (i == 0) begin : g_src
            assign in_data = {bus.d7, bus.d6, bus.d5, bus.d4,
                              bus.d3, bus.d2, bus.d1, bus.d0};
            assign in_sel  = bus.sel;
            assign in_vld  = bus.in_valid;
        end else begin : g_src
            assign in_data = lvl[i-1].out_data;
            assign in_sel  = lvl[i-1].out_sel;
            assign in_vld  = lvl[i-1].out_vld;
        end

        // 2:1 selects of this level: pair (2k, 2k+1) steered by sel[i];
        // unused upper slots are tied to zero.
        always_comb begin
            res_d = '0;
            for (int k = 0; k < NOUT; k++) begin
                res_d[k] = in_sel[i] ? in_data[2*k+1] : in_data[2*k];
            end
            sel_d = in_sel;
            vld_d = in_vld;
        end

        if (STAGE_REGS[i]) begin : g_reg
            logic [7:0][WIDTH-1:0] res_q;
            logic [2:0]            sel_q;
            logic                  vld_q;

            // Stage register: result, remaining select bits and valid move together.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_q <= '0;
                    sel_q <= '0;
                    vld_q <= 1'b0;
                end else begin
                    res_q <= res_d;
                    sel_q <= sel_d;
                    vld_q <= vld_d;
                end
            end

            assign out_data = res_q;
            assign out_sel  = sel_q;
            assign out_vld  = vld_q;
        end else begin : g_comb
            assign out_data = res_d;
            assign out_sel  = sel_d;
            assign out_vld  = vld_d;
        end
    end

    assign bus.y         = lvl[2].out_data[0];
    assign bus.out_valid = lvl[2].out_vld;

endmodule

// File: tb/tb_mux_8x1_structural.sv
// Scoreboard bench for mux_8x1_structural. Four builds share one stimulus
// stream: WIDTH=1 default regs (L=1), WIDTH=8 3'b111 (L=3), WIDTH=8 3'b000
// (L=0), WIDTH=8 3'b101 (L=2). Stimulus pushes d[sel] tagged with the
// cycle it must emerge on; a negedge monitor pops and compares.
module tb_mux_8x1_structural;

    typedef struct {
        logic [7:0] y;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;

    logic [7:0][7:0] dv;
    logic [2:0]      sel_s;
    logic            vin;

    exp_t       sbq [4][$];
    int         lat  [4] = '{1, 3, 0, 2};
    logic [7:0] mask [4] = '{8'h01, 8'hff, 8'hff, 8'hff};

    logic [3:0] ov;
    logic [7:0] yv [4];

    mux_8x1_structural_if #(.WIDTH(1)) if0 ();
    mux_8x1_structural_if #(.WIDTH(8)) if1 ();
    mux_8x1_structural_if #(.WIDTH(8)) if2 ();
    mux_8x1_structural_if #(.WIDTH(8)) if3 ();

    mux_8x1_structural #(.WIDTH(1))                          u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mux_8x1_structural #(.WIDTH(8), .STAGE_REGS(3'b111)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mux_8x1_structural #(.WIDTH(8), .STAGE_REGS(3'b000)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    mux_8x1_structural #(.WIDTH(8), .STAGE_REGS(3'b101)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign {if0.d7, if0.d6, if0.d5, if0.d4, if0.d3, if0.d2, if0.d1, if0.d0} =
           {dv[7][0], dv[6][0], dv[5][0], dv[4][0], dv[3][0], dv[2][0], dv[1][0], dv[0][0]};
    assign {if1.d7, if1.d6, if1.d5, if1.d4, if1.d3, if1.d2, if1.d1, if1.d0} = dv;
    assign {if2.d7, if2.d6, if2.d5, if2.d4, if2.d3, if2.d2, if2.d1, if2.d0} = dv;
    assign {if3.d7, if3.d6, if3.d5, if3.d4, if3.d3, if3.d2, if3.d1, if3.d0} = dv;
    assign if0.sel = sel_s;  assign if0.in_valid = vin;
    assign if1.sel = sel_s;  assign if1.in_valid = vin;
    assign if2.sel = sel_s;  assign if2.in_valid = vin;
    assign if3.sel = sel_s;  assign if3.in_valid = vin;

    assign ov    = {if3.out_valid, if2.out_valid, if1.out_valid, if0.out_valid};
    assign yv[0] = {7'b0, if0.y};
    assign yv[1] = if1.y;
    assign yv[2] = if2.y;
    assign yv[3] = if3.y;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one expected entry per DUT falls due on a given cycle at most.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                while (sbq[k].size() > 0 && sbq[k][0].cyc < cyc) begin
                    exp_t e;
                    e = sbq[k].pop_front();
                    n_cmp++; n_err++;
                    $display("FAIL overdue dut%0d cyc=%0d result y=%h never seen (due cyc %0d)", k, cyc, e.y, e.cyc);
                end
                if (sbq[k].size() > 0 && sbq[k][0].cyc == cyc) begin
                    exp_t e;
                    e = sbq[k].pop_front();
                    n_cmp++;
                    if (ov[k] !== 1'b1 || yv[k] !== e.y) begin
                        n_err++;
                        $display("FAIL result dut%0d cyc=%0d got y=%h ov=%b want y=%h ov=1", k, cyc, yv[k], ov[k], e.y);
                    end
                end else if (ov[k] !== 1'b0) begin
                    n_cmp++; n_err++;
                    $display("FAIL spurious_valid dut%0d cyc=%0d got ov=%b want ov=0", k, cyc, ov[k]);
                end
            end
        end
    end

    // Drive one request just after the clock edge and record what it must produce.
    task automatic issue(input logic v, input logic [7:0][7:0] dd, input logic [2:0] s);
        @(posedge clk);
        #1;
        vin   = v;
        dv    = dd;
        sel_s = s;
        if (v && rst_n) begin
            for (int k = 0; k < 4; k++) begin
                exp_t e;
                e.y   = dd[s] & mask[k];
                e.cyc = cyc + lat[k];
                sbq[k].push_back(e);
            end
        end
    endtask

    function automatic logic [7:0][7:0] rnd_d();
        logic [7:0][7:0] r;
        for (int k = 0; k < 8; k++) r[k] = 8'($urandom);
        return r;
    endfunction

    // Registered builds must show zero outputs while reset is held.
    task automatic reset_chk(input string nm);
        for (int k = 0; k < 4; k++) begin
            if (lat[k] != 0) begin
                n_cmp++;
                if (yv[k] !== 8'h00) begin
                    n_err++;
                    $display("FAIL %s_y dut%0d got %h want 00", nm, k, yv[k]);
                end
                n_cmp++;
                if (ov[k] !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s_ov dut%0d got %b want 0", nm, k, ov[k]);
                end
            end
        end
    endtask

    task automatic flush();
        for (int k = 0; k < 4; k++) sbq[k].delete();
    endtask

    initial begin
        logic [7:0][7:0] dd;
        logic [7:0]      pat;
        cyc   = 0;
        n_cmp = 0;
        n_err = 0;
        pat   = 8'b10110011;

        // Reset held with a live request: outputs must be zero before any edge.
        rst_n = 1'b0;
        vin   = 1'b1;
        dv    = '1;
        sel_s = 3'd7;
        #1;
        reset_chk("reset_async");
        issue(1'b1, '1, 3'd7);
        issue(1'b0, '1, 3'd7);
        reset_chk("reset_hold");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Sweep all codes with dN = A0+N.
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 8; k++) dd[k] = 8'hA0 + 8'(k);
            issue(1'b1, dd, 3'(s));
        end
        // Sweep with bit 0 of dN from pattern 10110011.
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 8; k++) dd[k] = {4'h5, 3'(k), pat[k]};
            issue(1'b1, dd, 3'(s));
        end
        // Single-hot d2.
        dd = '0;
        dd[2] = 8'h01;
        issue(1'b1, dd, 3'd2);
        issue(1'b1, dd, 3'd3);

        // Valid bubbles.
        for (int i = 0; i < 16; i++) issue(1'((i + 1) % 2), rnd_d(), 3'($urandom));
        // Random traffic.
        for (int i = 0; i < 200; i++) issue(1'($urandom_range(0, 3) != 0), rnd_d(), 3'($urandom));

        // Mid-stream reset with results in flight.
        for (int i = 0; i < 4; i++) issue(1'b1, rnd_d(), 3'($urandom));
        #1 rst_n = 1'b0;
        flush();
        #1 reset_chk("reset_mid");
        issue(1'b1, rnd_d(), 3'($urandom));
        issue(1'b0, rnd_d(), 3'($urandom));
        reset_chk("reset_mid_hold");
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 30; i++) issue(1'($urandom_range(0, 2) != 0), rnd_d(), 3'($urandom));

        // Drain and confirm everything that was expected came out.
        for (int i = 0; i < 6; i++) issue(1'b0, rnd_d(), 3'($urandom));
        @(negedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (sbq[k].size() != 0) begin
                n_err++;
                $display("FAIL drain dut%0d got %0d pending want 0", k, sbq[k].size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
